// File: rtl/irq_arbiter.sv
// irq_arbiter: platform-level external interrupt arbiter.
// Level-sensitive sources pass through a per-source gateway (pending / in_service),
// are filtered by enable and a global threshold, and the highest-priority
// candidate (lowest ID on ties) drives the machine external interrupt.
// Software retires sources through the claim/complete register at 0x48.
module irq_arbiter #(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic [7:0]         bus_addr,
  input  logic               bus_wen,
  input  logic               bus_ren,
  input  logic [31:0]        bus_wdata,
  output logic [31:0]        bus_rdata,
  output logic               external_interrupt
);

  localparam int ID_W = $clog2(NUM_SRC + 1);

  // Word addresses (byte address >> 2)
  localparam logic [5:0] WORD_ENABLE = 6'h10;
  localparam logic [5:0] WORD_THRESH = 6'h11;
  localparam logic [5:0] WORD_CLAIM  = 6'h12;
  localparam logic [5:0] WORD_PEND   = 6'h13;

  logic [PRIO_W-1:0]  prio_r [NUM_SRC];
  logic [NUM_SRC-1:0] enable_r;
  logic [PRIO_W-1:0]  threshold_r;
  logic [NUM_SRC-1:0] pending_r;
  logic [NUM_SRC-1:0] in_service_r;
  logic [ID_W-1:0]    best_id_r;
  logic [31:0]        rdata_r;
  logic               ext_irq_r;

  logic [5:0]         word_s;
  logic               unused_addr_s;
  logic [NUM_SRC-1:0] best_onehot_s;
  logic [NUM_SRC-1:0] claim_mask_s;
  logic [NUM_SRC-1:0] complete_mask_s;
  logic               claim_ok_s;
  logic [ID_W-1:0]    cand_id_s;
  logic [PRIO_W-1:0]  cand_prio_s;
  logic [31:0]        rdata_s;

  assign word_s             = bus_addr[7:2];
  assign unused_addr_s      = ^bus_addr[1:0];
  assign bus_rdata          = rdata_r;
  assign external_interrupt = ext_irq_r;

  // Claim / complete decode: a claim needs a read without a simultaneous write
  // and a best_id whose pending bit is still set.
  always_comb begin
    best_onehot_s   = '0;
    complete_mask_s = '0;
    claim_mask_s    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      best_onehot_s[i] = (best_id_r == ID_W'(i + 1));
      if (bus_wen && (word_s == WORD_CLAIM)) begin
        complete_mask_s[i] = (bus_wdata == 32'(i + 1)) && in_service_r[i];
      end else begin
        complete_mask_s[i] = 1'b0;
      end
    end
    claim_ok_s = bus_ren && !bus_wen && (word_s == WORD_CLAIM) &&
                 (best_id_r != '0) && (|(best_onehot_s & pending_r));
    if (claim_ok_s) begin
      claim_mask_s = best_onehot_s;
    end else begin
      claim_mask_s = '0;
    end
  end

  // Arbiter: strict '>' while scanning upward keeps the lowest ID on ties.
  always_comb begin
    cand_id_s   = '0;
    cand_prio_s = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pending_r[i] && enable_r[i] && (prio_r[i] > threshold_r) &&
          (prio_r[i] > cand_prio_s)) begin
        cand_id_s   = ID_W'(i + 1);
        cand_prio_s = prio_r[i];
      end else begin
        cand_prio_s = cand_prio_s;
      end
    end
  end

  // Read data mux for the register map; unmapped words read as zero.
  always_comb begin
    rdata_s = 32'd0;
    case (word_s)
      WORD_ENABLE: rdata_s = 32'(enable_r);
      WORD_THRESH: rdata_s = 32'(threshold_r);
      WORD_CLAIM: begin
        if (claim_ok_s) begin
          rdata_s = 32'(best_id_r);
        end else begin
          rdata_s = 32'd0;
        end
      end
      WORD_PEND:   rdata_s = 32'(pending_r);
      default: begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (word_s == 6'(i)) begin
            rdata_s = 32'(prio_r[i]);
          end else begin
            rdata_s = rdata_s;
          end
        end
      end
    endcase
  end

  // Configuration registers: priority, enable, threshold.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_SRC; i++) prio_r[i] <= '0;
      enable_r    <= '0;
      threshold_r <= '0;
    end else if (bus_wen) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (word_s == 6'(i)) prio_r[i] <= bus_wdata[PRIO_W-1:0];
      end
      if (word_s == WORD_ENABLE) enable_r    <= bus_wdata[NUM_SRC-1:0];
      if (word_s == WORD_THRESH) threshold_r <= bus_wdata[PRIO_W-1:0];
    end
  end

  // Gateway: level sources set pending unless in service; a claim wins over a set.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending_r    <= '0;
      in_service_r <= '0;
    end else begin
      pending_r    <= (pending_r | (src_irq & ~in_service_r)) & ~claim_mask_s;
      in_service_r <= (in_service_r | claim_mask_s) & ~complete_mask_s;
    end
  end

  // Registered arbiter result and interrupt request, updated together.
  always_ff @(posedge clock) begin
    if (reset) begin
      best_id_r <= '0;
      ext_irq_r <= 1'b0;
    end else begin
      best_id_r <= cand_id_s;
      ext_irq_r <= (cand_id_s != '0);
    end
  end

  // Read data: loads on a read, clears on any write, otherwise holds.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_r <= 32'd0;
    end else if (bus_wen) begin
      rdata_r <= 32'd0;
    end else if (bus_ren) begin
      rdata_r <= rdata_s;
    end else begin
      rdata_r <= rdata_r;
    end
  end

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter: read results are queued when a read is
// issued and popped/compared once bus_rdata is valid.
module tb_irq_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  src_irq;
  logic [7:0]  bus_addr;
  logic        bus_wen;
  logic        bus_ren;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        external_interrupt;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  irq_arbiter #(.NUM_SRC(8), .PRIO_W(3)) dut (
    .clock(clock), .reset(reset), .src_irq(src_irq),
    .bus_addr(bus_addr), .bus_wen(bus_wen), .bus_ren(bus_ren),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .external_interrupt(external_interrupt)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sb_compare();
    string t;
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_eq(t, bus_rdata, e);
    end
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data);
    bus_addr  = addr;
    bus_wdata = data;
    bus_wen   = 1'b1;
    tick();
    bus_wen   = 1'b0;
  endtask

  task automatic rd(input logic [7:0] addr, input logic [31:0] exp, input string tag);
    bus_addr = addr;
    bus_ren  = 1'b1;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    tick();
    bus_ren  = 1'b0;
    sb_compare();
  endtask

  task automatic check_irq(input string tag, input logic exp);
    check_eq(tag, {31'd0, external_interrupt}, {31'd0, exp});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; src_irq = 8'h00; bus_addr = 8'h00;
    bus_wen = 1'b0; bus_ren = 1'b0; bus_wdata = 32'd0;
    tick(); tick();
    reset = 1'b0;
    check_irq("rst_irq", 1'b0);
    check_eq("rst_rdata", bus_rdata, 32'd0);

    // Reset state: every register reads zero
    for (int i = 0; i < 8; i++) rd(8'(4 * i), 32'd0, "rst_prio");
    rd(8'h40, 32'd0, "rst_enable");
    rd(8'h44, 32'd0, "rst_thresh");
    rd(8'h48, 32'd0, "rst_claim");
    rd(8'h4C, 32'd0, "rst_pending");
    rd(8'h50, 32'd0, "unmapped");

    // Disabled source still pends but does not interrupt
    src_irq = 8'h04;
    tick();
    src_irq = 8'h00;
    rd(8'h4C, 32'h04, "dis_pending");
    check_irq("dis_irq", 1'b0);

    // Latency: pulse at edge N -> interrupt after N+1
    do_reset();
    wr(8'h08, 32'h0000_000B);           // keeps low 3 bits -> 3
    rd(8'h08, 32'd3, "prio_trunc");
    wr(8'h40, 32'h04);
    src_irq = 8'h04;
    tick();                             // edge N
    src_irq = 8'h00;
    check_irq("lat_n", 1'b0);
    tick();                             // edge N+1
    check_irq("lat_n1", 1'b1);
    rd(8'h48, 32'd3, "lat_claim");
    check_irq("lat_claim_n", 1'b1);
    tick();
    check_irq("lat_claim_n1", 1'b0);
    rd(8'h4C, 32'd0, "lat_pending");
    wr(8'h48, 32'd3);

    // Priority and tie-break, including back-to-back stale claim
    do_reset();
    wr(8'h00, 32'd2);
    wr(8'h14, 32'd5);
    wr(8'h0C, 32'd5);
    wr(8'h40, 32'h29);
    src_irq = 8'h29;
    tick(); tick();
    check_irq("tie_irq", 1'b1);
    rd(8'h48, 32'd4, "tie_claim1");
    rd(8'h48, 32'd0, "b2b_claim");
    rd(8'h48, 32'd6, "tie_claim2");
    tick();
    rd(8'h48, 32'd1, "tie_claim3");
    tick();
    rd(8'h48, 32'd0, "tie_claim4");
    check_irq("tie_done_irq", 1'b0);
    src_irq = 8'h00;

    // Threshold gating
    do_reset();
    wr(8'h04, 32'd2);
    wr(8'h40, 32'h02);
    wr(8'h44, 32'd2);
    src_irq = 8'h02;
    tick(); tick();
    check_irq("thr_block", 1'b0);
    wr(8'h44, 32'd1);
    check_irq("thr_edge1", 1'b0);
    tick();
    check_irq("thr_edge2", 1'b1);

    // Level re-trigger around claim/complete
    rd(8'h48, 32'd2, "lvl_claim");
    tick(); tick();
    rd(8'h4C, 32'd0, "lvl_no_repend");
    wr(8'h48, 32'd9);
    wr(8'h48, 32'd0);
    tick();
    rd(8'h4C, 32'd0, "lvl_bad_complete");
    wr(8'h48, 32'd2);
    rd(8'h4C, 32'd0, "lvl_cmpl_edge");
    rd(8'h4C, 32'h02, "lvl_repend");

    // Simultaneous write and read of claim: no claim side effect
    tick(); tick();
    check_irq("sim_irq", 1'b1);
    bus_addr = 8'h48; bus_wdata = 32'd0;
    bus_wen = 1'b1; bus_ren = 1'b1;
    exp_q.push_back(32'd0);
    tag_q.push_back("sim_rdata");
    tick();
    bus_wen = 1'b0; bus_ren = 1'b0;
    sb_compare();
    rd(8'h4C, 32'h02, "sim_pending");
    rd(8'h48, 32'd2, "sim_claim");

    // Reset mid-service clears in_service: held source re-pends
    do_reset();
    check_irq("mid_rst_irq", 1'b0);
    tick();
    rd(8'h4C, 32'h02, "mid_rst_pending");
    wr(8'h04, 32'd2);
    wr(8'h40, 32'h02);
    tick();
    check_irq("mid_rst_reirq", 1'b1);
    rd(8'h48, 32'd2, "mid_rst_claim");
    src_irq = 8'h00;

    if (exp_q.size() != 0) check_eq("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
